// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump transmitter.
// The frame is one header byte, two bytes per register, and one checksum byte.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CAPTURE,
        SEND_HI,
        SEND_LO,
        CSUM,
        DONE
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int BYTES_PER_FRAME = 18;

endpackage

// File: rtl/reg_dump.sv
// Walks the register-file read port 0..NUM_REGS-1 and streams a framed byte dump:
// A5, Rk hi/lo for each register, then the XOR of the data bytes.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int DATA_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [SEL_W-1:0]  SR_SEL,
    input  logic [DATA_W-1:0] SR_DATA,
    output logic [7:0]        Byte_Out,
    output logic              Byte_Valid,
    input  logic              Byte_Ready,
    output logic              Busy,
    output logic              Done
);

    state_t             state;
    logic [SEL_W-1:0]   index;
    logic [DATA_W-1:0]  shadow;
    logic [7:0]         checksum;
    logic               accept;
    logic               last_reg;

    assign accept   = Byte_Valid & Byte_Ready;
    assign last_reg = (index == SEL_W'(NUM_REGS - 1));

    // The read select idles at zero so nothing downstream sees a stale index.
    assign SR_SEL = (state == IDLE) ? '0 : index;

    // Each register is sampled in its own CAPTURE cycle; the high byte is
    // presented straight from SR_DATA so SEND_HI follows with no bubble.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            index      <= '0;
            shadow     <= '0;
            checksum   <= '0;
            Byte_Out   <= '0;
            Byte_Valid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        state      <= HDR;
                        index      <= '0;
                        checksum   <= '0;
                        Byte_Out   <= HDR_BYTE;
                        Byte_Valid <= 1'b1;
                        Busy       <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        state      <= CAPTURE;
                        Byte_Valid <= 1'b0;
                    end
                end
                CAPTURE: begin
                    shadow     <= SR_DATA;
                    Byte_Out   <= SR_DATA[DATA_W-1:DATA_W-8];
                    Byte_Valid <= 1'b1;
                    state      <= SEND_HI;
                end
                SEND_HI: begin
                    if (accept) begin
                        checksum <= checksum ^ Byte_Out;
                        Byte_Out <= shadow[7:0];
                        state    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (accept) begin
                        checksum <= checksum ^ Byte_Out;
                        if (last_reg) begin
                            // Fold the final data byte in directly; the register updates too late.
                            Byte_Out <= checksum ^ Byte_Out;
                            state    <= CSUM;
                        end else begin
                            index      <= index + 1'b1;
                            Byte_Valid <= 1'b0;
                            state      <= CAPTURE;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        Byte_Valid <= 1'b0;
                        Byte_Out   <= '0;
                        Done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: a register-file model feeds SR_DATA and
// accepted bytes are compared against a frame built directly from register values.
module tb_reg_dump;

    localparam int NREG = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Byte_Ready = 1'b0;
    logic [2:0]  SR_SEL;
    logic [15:0] SR_DATA;
    logic [7:0]  Byte_Out;
    logic        Byte_Valid;
    logic        Busy;
    logic        Done;

    logic [15:0] rf [NREG];
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base = 0;
    int done_cnt = 0;
    int done_rel = -1;

    reg_dump #(.NUM_REGS(8), .SEL_W(3), .DATA_W(16)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .SR_SEL(SR_SEL),
        .SR_DATA(SR_DATA),
        .Byte_Out(Byte_Out),
        .Byte_Valid(Byte_Valid),
        .Byte_Ready(Byte_Ready),
        .Busy(Busy),
        .Done(Done)
    );

    assign SR_DATA = rf[SR_SEL];

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Log what the sink actually takes, half a cycle away from the active edge.
    always @(negedge Clk) begin
        if (Reset && Byte_Valid && Byte_Ready) got_q.push_back(Byte_Out);
        if (Done) begin
            done_cnt++;
            done_rel = cyc - base;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_log();
        got_q.delete();
        done_cnt = 0;
        done_rel = -1;
    endtask

    // Reference frame: header, each register MSB first, XOR of the data bytes.
    task automatic make_expected(input logic [15:0] v [NREG]);
        logic [7:0] cs;
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NREG; i++) begin
            exp_q.push_back(v[i] / 256);
            exp_q.push_back(v[i] % 256);
            cs = cs ^ 8'(v[i] / 256) ^ 8'(v[i] % 256);
        end
        exp_q.push_back(cs);
    endtask

    // Leaves the bench in cycle 1 of the new frame.
    task automatic pulse_start();
        step();
        Start = 1'b1;
        base = cyc;
        step();
        Start = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int limit);
        while (done_cnt == 0 && (cyc - base) < limit) begin
            step();
            case (mode)
                0: Byte_Ready = 1'b1;
                1: Byte_Ready = ~Byte_Ready;
                default: Byte_Ready = ($urandom_range(0, 3) != 0);
            endcase
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("[TB] FAIL frame_timeout got done_cnt=%0d exp>=1 after %0d cycles", done_cnt, limit);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREG; i++) rf[i] = 16'h0000;
        Reset = 1'b0;
        Start = 1'b1;
        Byte_Ready = 1'b1;
        repeat (3) step();
        @(negedge Clk);
        total++;
        if (Byte_Valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", Byte_Valid); end
        total++;
        if (Byte_Out !== 8'h00) begin bad++; $display("[TB] FAIL reset_byte got=%h exp=00", Byte_Out); end
        total++;
        if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", Busy); end
        total++;
        if (Done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", Done); end
        total++;
        if (SR_SEL !== 3'd0) begin bad++; $display("[TB] FAIL reset_sel got=%0d exp=0", SR_SEL); end
        step();
        Start = 1'b0;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int n_err;
        logic exp_busy;
        for (int i = 0; i < NREG; i++) rf[i] = 16'h0000;
        rf[0] = 16'hBEEF;
        Byte_Ready = 1'b1;
        clear_log();
        pulse_start();
        for (int r = 1; r <= 30; r++) begin
            @(negedge Clk);
            exp_busy = (r <= 27);
            total++;
            if (Busy !== exp_busy) begin
                bad++;
                $display("[TB] FAIL basic_busy cycle=%0d got=%b exp=%b", r, Busy, exp_busy);
            end
            step();
        end
        make_expected(rf);
        total++;
        if (exp_q[17] !== 8'h51) begin bad++; $display("[TB] FAIL basic_model_csum got=%h exp=51", exp_q[17]); end
        n_err = 0;
        if (got_q.size() != exp_q.size()) n_err = 1;
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n_err++;
        total++;
        if (n_err != 0) begin
            bad++;
            $display("[TB] FAIL basic_frame wrong=%0d got_len=%0d exp_len=%0d", n_err, got_q.size(), exp_q.size());
        end
        total++;
        if (done_cnt != 1 || done_rel != 27) begin
            bad++;
            $display("[TB] FAIL basic_done got cnt=%0d cycle=%0d exp cnt=1 cycle=27", done_cnt, done_rel);
        end
    endtask

    task automatic test_stall();
        int n_err;
        for (int i = 0; i < NREG; i++) rf[i] = 16'h0000;
        rf[0] = 16'hBEEF;
        Byte_Ready = 1'b1;
        clear_log();
        pulse_start();
        for (int r = 1; r <= 40; r++) begin
            Byte_Ready = !(r >= 12 && r <= 16);
            @(negedge Clk);
            if (r >= 12 && r <= 16) begin
                total++;
                if (Byte_Valid !== 1'b1 || Byte_Out !== rf[3][15:8]) begin
                    bad++;
                    $display("[TB] FAIL stall_hold cycle=%0d got valid=%b byte=%h exp valid=1 byte=%h",
                             r, Byte_Valid, Byte_Out, rf[3][15:8]);
                end
            end
            step();
        end
        make_expected(rf);
        n_err = 0;
        if (got_q.size() != exp_q.size()) n_err = 1;
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n_err++;
        total++;
        if (n_err != 0) begin
            bad++;
            $display("[TB] FAIL stall_frame wrong=%0d got_len=%0d exp_len=%0d", n_err, got_q.size(), exp_q.size());
        end
        total++;
        if (done_cnt != 1 || done_rel != 32) begin
            bad++;
            $display("[TB] FAIL stall_done got cnt=%0d cycle=%0d exp cnt=1 cycle=32", done_cnt, done_rel);
        end
    endtask

    task automatic test_ignored_start();
        int n_err;
        for (int i = 0; i < NREG; i++) rf[i] = 16'($urandom);
        Byte_Ready = 1'b1;
        clear_log();
        pulse_start();
        for (int r = 1; r <= 40; r++) begin
            Start = (r == 5 || r == 27);
            Byte_Ready = 1'b1;
            @(negedge Clk);
            if (r == 28 || r == 35) begin
                total++;
                if (Busy !== 1'b0 || Byte_Valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL ignore_idle cycle=%0d got busy=%b valid=%b exp busy=0 valid=0",
                             r, Busy, Byte_Valid);
                end
            end
            step();
        end
        Start = 1'b0;
        make_expected(rf);
        n_err = 0;
        if (got_q.size() != reg_dump_pkg::BYTES_PER_FRAME) n_err = 1;
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n_err++;
        total++;
        if (n_err != 0) begin
            bad++;
            $display("[TB] FAIL ignore_frame wrong=%0d got_len=%0d exp_len=%0d", n_err, got_q.size(),
                     reg_dump_pkg::BYTES_PER_FRAME);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("[TB] FAIL ignore_done got cnt=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int n_err;
        for (int i = 0; i < NREG; i++) rf[i] = 16'($urandom);
        Byte_Ready = 1'b1;
        clear_log();
        pulse_start();
        repeat (9) step();
        Reset = 1'b0;
        Byte_Ready = 1'b0;
        step();
        @(negedge Clk);
        total++;
        if (Byte_Valid !== 1'b0 || SR_SEL !== 3'd0 || Busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_state got valid=%b sel=%0d busy=%b exp valid=0 sel=0 busy=0",
                     Byte_Valid, SR_SEL, Busy);
        end
        step();
        Reset = 1'b1;
        Byte_Ready = 1'b1;
        repeat (10) step();
        make_expected(rf);
        n_err = 0;
        if (got_q.size() != 6) n_err = 1;
        else for (int i = 0; i < 6; i++) if (got_q[i] !== exp_q[i]) n_err++;
        total++;
        if (n_err != 0) begin
            bad++;
            $display("[TB] FAIL abort_partial wrong=%0d got_len=%0d exp_len=6", n_err, got_q.size());
        end
        total++;
        if (done_cnt != 0) begin bad++; $display("[TB] FAIL abort_no_done got cnt=%0d exp=0", done_cnt); end
        clear_log();
        pulse_start();
        run_frame(0, 60);
        n_err = 0;
        if (got_q.size() != exp_q.size()) n_err = 1;
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n_err++;
        total++;
        if (n_err != 0) begin
            bad++;
            $display("[TB] FAIL abort_refresh wrong=%0d got_len=%0d exp_len=%0d", n_err, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_snapshot();
        int n_err;
        logic [15:0] seen [NREG];
        for (int i = 0; i < NREG; i++) rf[i] = 16'($urandom);
        rf[1] = rf[1] & 16'h7FFF;
        rf[5] = rf[5] ^ 16'h8000;
        if (rf[5] == 16'h1234) rf[5] = 16'h4321;
        seen = rf;
        seen[5] = 16'h1234;
        Byte_Ready = 1'b1;
        clear_log();
        pulse_start();
        for (int r = 1; r <= 30; r++) begin
            if (r == 6) rf[1] = 16'hFFFF;
            if (r == 8) rf[5] = 16'h1234;
            step();
        end
        make_expected(seen);
        n_err = 0;
        if (got_q.size() != exp_q.size()) n_err = 1;
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n_err++;
        total++;
        if (n_err != 0) begin
            bad++;
            $display("[TB] FAIL snapshot_frame wrong=%0d got_len=%0d exp_len=%0d", n_err, got_q.size(), exp_q.size());
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("[TB] FAIL snapshot_done got cnt=%0d exp=1", done_cnt); end
    endtask

    task automatic test_toggle();
        int n_err;
        for (int i = 0; i < NREG; i++) rf[i] = 16'(16'h0101 * (i + 1));
        Byte_Ready = 1'b0;
        clear_log();
        pulse_start();
        run_frame(1, 80);
        make_expected(rf);
        n_err = 0;
        if (got_q.size() != exp_q.size()) n_err = 1;
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n_err++;
        total++;
        if (n_err != 0) begin
            bad++;
            $display("[TB] FAIL toggle_frame wrong=%0d got_len=%0d exp_len=%0d", n_err, got_q.size(), exp_q.size());
        end
        total++;
        if (got_q.size() != 18 || got_q[17] !== 8'h00) begin
            bad++;
            $display("[TB] FAIL toggle_csum got_len=%0d exp csum=00", got_q.size());
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("[TB] FAIL toggle_done got cnt=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random();
        int n_err;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NREG; i++) rf[i] = 16'($urandom);
            Byte_Ready = 1'b1;
            clear_log();
            pulse_start();
            run_frame(2, 120);
            make_expected(rf);
            n_err = 0;
            if (got_q.size() != exp_q.size()) n_err = 1;
            else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n_err++;
            total++;
            if (n_err != 0) begin
                bad++;
                $display("[TB] FAIL random_frame iter=%0d wrong=%0d got_len=%0d exp_len=%0d",
                         t, n_err, got_q.size(), exp_q.size());
            end
            total++;
            if (done_cnt != 1) begin bad++; $display("[TB] FAIL random_done iter=%0d got cnt=%0d exp=1", t, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignored_start();
        test_reset_mid();
        test_snapshot();
        test_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
